// File: rtl/bram_port_arbiter_if.sv
// Purpose: bundles requester command/response signals and RAM port A signals for bram_port_arbiter.
// Latency: n/a (signal bundle only).
// Backpressure: requesters hold req until ack; no other stall path.
// Ports (slave = arbiter side):
//   req/we/addr/wdata  requester commands, packed per requester
//   ack/rvalid/rdata   per-requester accept and read-return
//   mem_*              RAM port A (wren_a, address_a, data_a, q_a)
interface bram_port_arbiter_if #(
  parameter int NUM_REQ = 3,
  parameter int DATA_W  = 8,
  parameter int ADDR_W  = 10
);
  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ-1:0]        we;
  logic [NUM_REQ*ADDR_W-1:0] addr;
  logic [NUM_REQ*DATA_W-1:0] wdata;
  logic [NUM_REQ-1:0]        ack;
  logic [NUM_REQ-1:0]        rvalid;
  logic [DATA_W-1:0]         rdata;
  logic                      mem_wren;
  logic [ADDR_W-1:0]         mem_address;
  logic [DATA_W-1:0]         mem_data;
  logic [DATA_W-1:0]         mem_q;

  modport slave (
    input  req, we, addr, wdata, mem_q,
    output ack, rvalid, rdata, mem_wren, mem_address, mem_data
  );

  modport master (
    output req, we, addr, wdata, mem_q,
    input  ack, rvalid, rdata, mem_wren, mem_address, mem_data
  );
endinterface

// File: rtl/bram_port_arbiter.sv
// Purpose: shares synchronous RAM port A among NUM_REQ requesters (round-robin or fixed priority).
// Latency: req sampled -> ack 1 edge; req sampled -> rvalid 2 edges (reads only).
// Backpressure: requesters hold req until ack; a just-acked requester is skipped for one edge.
// Ports:
//   clk_sys  system clock, rising edge
//   reset_n  async active-low reset (release expected synchronous to clk_sys)
//   bus      bram_port_arbiter_if.slave: requester commands/responses and RAM port A
module bram_port_arbiter #(
  parameter int NUM_REQ    = 3,
  parameter int DATA_W     = 8,
  parameter int ADDR_W     = 10,
  parameter int FIXED_PRIO = 0
) (
  input  logic                  clk_sys,
  input  logic                  reset_n,
  bram_port_arbiter_if.slave    bus
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  // Registered state
  logic [PTR_W-1:0]   r_rr_ptr;
  logic [NUM_REQ-1:0] r_ack;
  logic [NUM_REQ-1:0] r_rd_mask;   // read issued last edge; becomes rvalid next edge
  logic [NUM_REQ-1:0] r_rvalid;
  logic               r_mem_wren;
  logic [ADDR_W-1:0]  r_mem_address;
  logic [DATA_W-1:0]  r_mem_data;

  // Arbitration wires
  logic [NUM_REQ-1:0] w_elig;
  logic               w_found;
  logic [PTR_W-1:0]   w_win;
  logic [NUM_REQ-1:0] w_win_oh;
  logic               w_win_we;
  logic [ADDR_W-1:0]  w_win_addr;
  logic [DATA_W-1:0]  w_win_data;
  int                 w_idx;

  always_comb begin
    // The requester acked last edge still presents its old command, so mask it.
    w_elig  = bus.req & ~r_ack;
    w_found = 1'b0;
    w_win   = '0;
    w_idx   = 0;
    if (FIXED_PRIO != 0) begin
      // Descending scan: the last hit is the lowest eligible index.
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
        if (w_elig[i]) begin
          w_found = 1'b1;
          w_win   = PTR_W'(i);
        end
      end
    end else begin
      // Scan offsets NUM_REQ..1 from rr_ptr; the last hit is the first one after rr_ptr.
      for (int i = NUM_REQ; i >= 1; i--) begin
        w_idx = int'(r_rr_ptr) + i;
        if (w_idx >= NUM_REQ) begin
          w_idx = w_idx - NUM_REQ;
        end
        if (w_elig[w_idx]) begin
          w_found = 1'b1;
          w_win   = PTR_W'(w_idx);
        end
      end
    end
  end

  always_comb begin
    w_win_oh        = '0;
    w_win_oh[w_win] = w_found;
    w_win_we        = bus.we[w_win];
    w_win_addr      = bus.addr[w_win*ADDR_W +: ADDR_W];
    w_win_data      = bus.wdata[w_win*DATA_W +: DATA_W];
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_rr_ptr      <= PTR_W'(NUM_REQ - 1);
      r_ack         <= '0;
      r_rd_mask     <= '0;
      r_rvalid      <= '0;
      r_mem_wren    <= 1'b0;
      r_mem_address <= '0;
      r_mem_data    <= '0;
    end else begin
      r_ack     <= w_win_oh;
      r_rvalid  <= r_rd_mask;
      r_rd_mask <= (w_found && !w_win_we) ? w_win_oh : '0;
      r_mem_wren <= w_found & w_win_we;
      if (w_found) begin
        r_mem_address <= w_win_addr;
        r_mem_data    <= w_win_data;
        r_rr_ptr      <= w_win;
      end
    end
  end

  assign bus.ack         = r_ack;
  assign bus.rvalid      = r_rvalid;
  assign bus.mem_wren    = r_mem_wren;
  assign bus.mem_address = r_mem_address;
  assign bus.mem_data    = r_mem_data;
  // RAM output register already aligns q_a with rvalid.
  assign bus.rdata       = bus.mem_q;

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Purpose: directed and scoreboarded random checks of bram_port_arbiter (RR and fixed priority).
// Latency: n/a.
// Backpressure: bench requesters hold req until ack.
module tb_bram_port_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  bram_port_arbiter_if #(.NUM_REQ(3), .DATA_W(8), .ADDR_W(10)) rr_if ();
  bram_port_arbiter_if #(.NUM_REQ(3), .DATA_W(8), .ADDR_W(10)) fp_if ();

  bram_port_arbiter #(.NUM_REQ(3), .DATA_W(8), .ADDR_W(10), .FIXED_PRIO(0)) dut_rr (
    .clk_sys(clk), .reset_n(rst_n), .bus(rr_if)
  );
  bram_port_arbiter #(.NUM_REQ(3), .DATA_W(8), .ADDR_W(10), .FIXED_PRIO(1)) dut_fp (
    .clk_sys(clk), .reset_n(rst_n), .bus(fp_if)
  );

  // RAM model for the round-robin instance: 1-cycle registered read, bench preload port.
  logic [7:0] ram [0:1023];
  logic [7:0] rr_q;
  logic       tb_wr = 1'b0;
  logic [9:0] tb_wa = '0;
  logic [7:0] tb_wd = '0;
  always @(posedge clk) begin
    if (tb_wr) ram[tb_wa] <= tb_wd;
    else if (rr_if.mem_wren) ram[rr_if.mem_address] <= rr_if.mem_data;
    rr_q <= ram[rr_if.mem_address];
  end
  assign rr_if.mem_q = rr_q;
  assign fp_if.mem_q = 8'h00;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [7:0] shadow [0:15];
  int         waitc [3];
  logic [2:0] exp_rv;
  logic [7:0] exp_rd;
  logic [9:0] a_i;

  initial begin
    rr_if.req = '0; rr_if.we = '0; rr_if.addr = '0; rr_if.wdata = '0;
    fp_if.req = '0; fp_if.we = '0; fp_if.addr = '0; fp_if.wdata = '0;
    exp_rv = '0; exp_rd = '0;
    for (int i = 0; i < 3; i++) waitc[i] = 0;

    // Preload RAM while in reset.
    tb_wr = 1'b1;
    for (int a = 0; a < 16; a++) begin
      tb_wa = 10'(a); tb_wd = 8'(8'hA0 + a); shadow[a] = 8'(8'hA0 + a);
      tick();
    end
    for (int a = 16; a < 19; a++) begin
      tb_wa = 10'(a); tb_wd = 8'(a);
      tick();
    end
    tb_wa = 10'h100; tb_wd = 8'h00;
    tick();
    tb_wr = 1'b0;

    // Reset state
    chk("rst_ack", rr_if.ack, 0);
    chk("rst_rvalid", rr_if.rvalid, 0);
    chk("rst_wren", rr_if.mem_wren, 0);
    chk("rst_addr", rr_if.mem_address, 0);
    chk("rst_data", rr_if.mem_data, 0);
    rst_n = 1'b1;

    // 1: all requesters read, RR order 0,1,2,0,...
    rr_if.req  = 3'b111;
    rr_if.we   = 3'b000;
    rr_if.addr = {10'h012, 10'h011, 10'h010};
    for (int t = 0; t < 6; t++) begin
      tick();
      chk("t1_ack", rr_if.ack, 32'(3'b001 << (t % 3)));
      chk("t1_addr", rr_if.mem_address, 32'(10'h010 + (t % 3)));
      if (t > 0) begin
        chk("t1_rvalid", rr_if.rvalid, 32'(3'b001 << ((t - 1) % 3)));
        chk("t1_rdata", rr_if.rdata, 32'(8'h10 + ((t - 1) % 3)));
      end
    end
    rr_if.req = 3'b000;
    tick();
    chk("t1_ack_idle", rr_if.ack, 0);
    chk("t1_rvalid_last", rr_if.rvalid, 32'b100);
    chk("t1_rdata_last", rr_if.rdata, 32'h12);
    tick();

    // 2: req0 held, writes 0x3A to 0x005 every 2nd cycle
    rr_if.req   = 3'b001;
    rr_if.we    = 3'b001;
    rr_if.addr  = {10'h000, 10'h000, 10'h005};
    rr_if.wdata = {8'h00, 8'h00, 8'h3A};
    for (int t = 0; t < 4; t++) begin
      tick();
      chk("t2_ack_on", rr_if.ack, 32'b001);
      chk("t2_wren_on", rr_if.mem_wren, 1);
      chk("t2_addr", rr_if.mem_address, 32'h005);
      chk("t2_data", rr_if.mem_data, 32'h3A);
      chk("t2_rvalid", rr_if.rvalid, 0);
      tick();
      chk("t2_ack_off", rr_if.ack, 0);
      chk("t2_wren_off", rr_if.mem_wren, 0);
      chk("t2_rvalid", rr_if.rvalid, 0);
    end
    rr_if.req = 3'b000;
    tick();
    chk("t2_ram", ram[5], 32'h3A);

    // 3: write 0x55 to 0x100 then read it in the next slot
    rr_if.req   = 3'b001;
    rr_if.we    = 3'b001;
    rr_if.addr  = {10'h000, 10'h100, 10'h100};
    rr_if.wdata = {8'h00, 8'h00, 8'h55};
    tick();
    chk("t3_wr_ack", rr_if.ack, 32'b001);
    chk("t3_wren", rr_if.mem_wren, 1);
    rr_if.req = 3'b010;
    rr_if.we  = 3'b000;
    tick();
    chk("t3_rd_ack", rr_if.ack, 32'b010);
    chk("t3_rd_wren", rr_if.mem_wren, 0);
    rr_if.req = 3'b000;
    tick();
    chk("t3_rvalid", rr_if.rvalid, 32'b010);
    chk("t3_rdata", rr_if.rdata, 32'h55);
    tick();

    // 4: fixed priority
    fp_if.req = 3'b101;
    fp_if.we  = 3'b000;
    tick();
    chk("t4_ack_a", fp_if.ack, 32'b001);
    tick();
    chk("t4_ack_b", fp_if.ack, 32'b100);
    chk("t4_rvalid", fp_if.rvalid, 32'b001);
    tick();
    chk("t4_ack_c", fp_if.ack, 32'b001);
    tick();
    chk("t4_ack_d", fp_if.ack, 32'b100);
    fp_if.req = 3'b111;
    tick();
    chk("t4_ack_e", fp_if.ack, 32'b001);
    tick();
    chk("t4_prio_1_over_2", fp_if.ack, 32'b010);
    fp_if.req = 3'b000;
    tick();

    // 5: reset right after a read ack drops the read
    rr_if.req  = 3'b001;
    rr_if.we   = 3'b000;
    rr_if.addr = {10'h012, 10'h011, 10'h010};
    tick();
    chk("t5_ack", rr_if.ack, 32'b001);
    rr_if.req = 3'b000;
    rst_n = 1'b0;
    #1;
    chk("t5_rst_ack", rr_if.ack, 0);
    chk("t5_rst_rvalid", rr_if.rvalid, 0);
    chk("t5_rst_wren", rr_if.mem_wren, 0);
    chk("t5_rst_addr", rr_if.mem_address, 0);
    tick();
    chk("t5_no_rvalid", rr_if.rvalid, 0);
    rr_if.req = 3'b111;
    rst_n = 1'b1;
    tick();
    chk("t5_first_grant", rr_if.ack, 32'b001);
    chk("t5_rvalid_post", rr_if.rvalid, 0);
    rr_if.req = 3'b000;
    tick();
    chk("t5_rvalid_new", rr_if.rvalid, 32'b001);
    chk("t5_rdata_new", rr_if.rdata, 32'h10);
    tick();
    tick();

    // 6: random traffic against a scoreboard (addresses 0..15)
    exp_rv = '0;
    for (int c = 0; c < 3000; c++) begin
      tick();
      chk("r_ack_onehot0", 32'($onehot0(rr_if.ack)), 1);
      chk("r_rvalid", rr_if.rvalid, exp_rv);
      if (exp_rv != 0) chk("r_rdata", rr_if.rdata, exp_rd);
      if (rr_if.ack == 0) chk("r_idle_wren", rr_if.mem_wren, 0);
      exp_rv = '0;
      for (int i = 0; i < 3; i++) begin
        a_i = rr_if.addr[i*10 +: 10];
        if (rr_if.ack[i]) begin
          chk("r_ack_req", rr_if.req[i], 1);
          chk("r_wait_bound", 32'(waitc[i] <= 3), 1);
          chk("r_wren", rr_if.mem_wren, rr_if.we[i]);
          chk("r_addr", rr_if.mem_address, a_i);
          if (rr_if.we[i]) begin
            chk("r_wdata", rr_if.mem_data, rr_if.wdata[i*8 +: 8]);
            shadow[a_i[3:0]] = rr_if.wdata[i*8 +: 8];
          end else begin
            exp_rv = 3'(3'b001 << i);
            exp_rd = shadow[a_i[3:0]];
          end
          rr_if.req[i]          = ($urandom_range(0, 3) != 0);
          rr_if.we[i]           = 1'($urandom_range(0, 1));
          rr_if.addr[i*10 +: 10] = 10'($urandom_range(0, 15));
          rr_if.wdata[i*8 +: 8]  = 8'($urandom_range(0, 255));
          waitc[i] = 0;
        end else if (rr_if.req[i]) begin
          waitc[i]++;
        end else if ($urandom_range(0, 1) != 0) begin
          rr_if.req[i]          = 1'b1;
          rr_if.we[i]           = 1'($urandom_range(0, 1));
          rr_if.addr[i*10 +: 10] = 10'($urandom_range(0, 15));
          rr_if.wdata[i*8 +: 8]  = 8'($urandom_range(0, 255));
          waitc[i] = 0;
        end
      end
    end
    rr_if.req = 3'b000;
    tick();
    chk("r_rvalid_tail", rr_if.rvalid, exp_rv);
    if (exp_rv != 0) chk("r_rdata_tail", rr_if.rdata, exp_rd);
    for (int i = 0; i < 3; i++) chk("r_wait_tail", 32'(waitc[i] <= 3), 1);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
